vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
// - Sequences the VGA pixel datapath: generates pixel-rate enable, VGA clock, h/v pixel counters,
//   hsync/vsync, vga_blank_n ("bright") and frame-start pulse for the colour bit generator.
// - Resynchronises the 9 colour switches and latches them once per frame, so the bit generator
//   never changes colour mid-frame. Sits between board I/O and the bitgen / DAC pins.
// PARAMETERS
// - CLK_DIV    2    system clocks per pixel; even, >= 2
// - H_VISIBLE  640  visible pixels per line
// - H_FP       16   horizontal front porch, pixels
// - H_SYNC     96   hsync pulse width, pixels
// - H_BP       48   horizontal back porch, pixels
// - V_VISIBLE  480  visible lines per frame
// - V_FP       10   vertical front porch, lines
// - V_SYNC     2    vsync pulse width, lines
// - V_BP       33   vertical back porch, lines
// PORTS
// - clk          in   1   system clock (50 MHz)
// - rst_n        in   1   asynchronous, active-low reset
// - sw           in   9   raw colour switches {R[2:0],G[2:0],B[2:0]}, asynchronous to clk
// - vga_clk      out  1   pixel clock to DAC, period CLK_DIV clk
// - vga_hs       out  1   horizontal sync, active low
// - vga_vs       out  1   vertical sync, active low
// - vga_blank_n  out  1   high while (hcount,vcount) is in the visible region
// - vga_sync_n   out  1   constant 0 (sync-on-green unused)
// - hcount       out  10  current pixel column, 0..H_TOTAL-1
// - vcount       out  10  current line, 0..V_TOTAL-1
// - frame_start  out  1   one-clk pulse at start of each frame
// - color_sw     out  9   frame-stable colour word to bitgen
// BEHAVIOUR
// - One clock domain (clk); rst_n asserts asynchronously, all state flops clear immediately.
// - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
// - Divider: div_cnt counts 0..CLK_DIV-1, wraps to 0; pix_en = (div_cnt==CLK_DIV-1).
//   vga_clk = registered (div_cnt >= CLK_DIV/2); duty 50%; rises mid-pixel, counters update on its fall.
// - Counters advance only on clk edges where pix_en=1: hcount+1; at H_TOTAL-1 hcount->0 and
//   vcount+1; at (H_TOTAL-1, V_TOTAL-1) both -> 0 (frame wrap). Never exceed TOTAL-1.
// - vga_hs, vga_vs, vga_blank_n are flops computed from next-state counters, so they always match
//   hcount/vcount on the same cycle (zero relative latency):
//   vga_hs = 0 iff H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC (656..751);
//   vga_vs = 0 iff V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC (490..491);
//   vga_blank_n = 1 iff hcount < H_VISIBLE and vcount < V_VISIBLE.
// - sw passes a 2-flop synchroniser (sw_s, reset 0). On the frame-wrap edge color_sw <= sw_s;
//   color_sw holds otherwise. Switch changes mid-frame appear only from next frame's pixel (0,0).
// - frame_start = 1 for exactly the first clk cycle after a frame wrap (counters newly (0,0));
//   not asserted out of reset.
// - Reset values: div_cnt=0, vga_clk=0, hcount=0, vcount=0, vga_hs=1, vga_vs=1, vga_blank_n=1,
//   frame_start=0, color_sw=0, sync flops=0; vga_sync_n=0 always.
// - Reset mid-line/mid-frame: outputs return to reset values asynchronously; on release timing
//   restarts from (0,0) with a full-length first line/frame; no partial sync pulses beyond
//   the one truncated by reset.
// - First frame after reset displays color_sw=0 (black); switches take effect at first wrap.
// TESTING
// - Reset: hold rst_n=0 -> hcount=vcount=0, vga_hs=vga_vs=1, vga_blank_n=1, color_sw=0, frame_start=0.
// - Line timing: free run -> vga_blank_n falls at hcount=640 (1280 clk after line start); vga_hs low
//   for hcount 656..751 = 192 clk; line period exactly 1600 clk.
// - Frame timing: vga_vs low for vcount 490..491 = 3200 clk; frame_start pulses every 840000 clk,
//   width 1 clk; vga_blank_n low for all of lines 480..524.
// - Colour latch: sw=9'h1C0 set at vcount=100 -> color_sw stays 0 until frame wrap, then 9'h1C0
//   coincident with frame_start; sw toggled 1 clk before wrap edge -> not captured (sync latency).
// - Async reset mid-frame at (hcount=700,vcount=491): outputs go to reset values within the same
//   cycle without a clk edge; after release next hs pulse begins at hcount=656 of line 0.
// - vga_clk: period 2 clk, 50% duty; every hcount change coincides with a vga_clk falling edge.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// vga_timing_ctrl
//   Pixel-rate sequencer for the VGA datapath. It divides the system clock down
//   to the pixel rate, runs the horizontal/vertical pixel counters, and produces
//   hsync/vsync/blank aligned to those counters. It also gives the bit generator
//   a frame-start pulse and a colour word that only changes between frames.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   sw[8:0]      in   raw colour switches {R[2:0],G[2:0],B[2:0]}, async to clk
//   vga_clk      out  pixel clock to DAC, period CLK_DIV clk, 50% duty
//   vga_hs       out  horizontal sync, active low
//   vga_vs       out  vertical sync, active low
//   vga_blank_n  out  high while (hcount,vcount) is inside the visible region
//   vga_sync_n   out  tied low (sync-on-green unused)
//   hcount[9:0]  out  current pixel column
//   vcount[9:0]  out  current line
//   frame_start  out  one-clk pulse when the counters have just wrapped to (0,0)
//   color_sw[8:0] out colour word, updated only on the frame-wrap edge
// ----------------------------------------------------------------------------
module vga_timing_ctrl #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] sw,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       frame_start,
  output logic [8:0] color_sw
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_vga_clk;
  logic [9:0]       r_hcount;
  logic [9:0]       r_vcount;
  logic             r_hs;
  logic             r_vs;
  logic             r_blank_n;
  logic             r_frame_start;
  logic [8:0]       r_color_sw;
  logic [8:0]       r_sw_meta;
  logic [8:0]       r_sw_s;

  logic             w_pix_en;
  logic             w_wrap;
  logic [DIV_W-1:0] w_div_nxt;
  logic [9:0]       w_h_nxt;
  logic [9:0]       w_v_nxt;

  always_comb begin
    w_pix_en  = (r_div_cnt == DIV_LAST);
    w_div_nxt = w_pix_en ? '0 : r_div_cnt + DIV_W'(1);
    w_wrap    = w_pix_en && (r_hcount == H_LAST) && (r_vcount == V_LAST);
    w_h_nxt   = r_hcount;
    w_v_nxt   = r_vcount;
    if (w_pix_en) begin
      if (r_hcount == H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_vcount == V_LAST) ? '0 : r_vcount + 10'd1;
      end else begin
        w_h_nxt = r_hcount + 10'd1;
      end
    end
  end

  // Sync/blank and vga_clk are registered from the next-state counter and
  // divider values, so they line up with hcount/vcount on the same cycle and
  // vga_clk falls on exactly the edge where the counters step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_vga_clk     <= 1'b0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b1;
      r_frame_start <= 1'b0;
      r_color_sw    <= '0;
      r_sw_meta     <= '0;
      r_sw_s        <= '0;
    end else begin
      r_div_cnt     <= w_div_nxt;
      r_vga_clk     <= (w_div_nxt >= DIV_HALF);
      r_hcount      <= w_h_nxt;
      r_vcount      <= w_v_nxt;
      r_hs          <= !((w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END));
      r_vs          <= !((w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END));
      r_blank_n     <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
      r_frame_start <= w_wrap;
      r_sw_meta     <= sw;
      r_sw_s        <= r_sw_meta;
      if (w_wrap) begin
        r_color_sw <= r_sw_s;
      end
    end
  end

  assign vga_clk     = r_vga_clk;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  assign vga_sync_n  = 1'b0;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign frame_start = r_frame_start;
  assign color_sw    = r_color_sw;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_ctrl
//   Two instances share clock, reset and switches: a small-geometry instance
//   that runs several whole frames (vertical timing, colour latch, mid-frame
//   reset) and a default 640x480 instance for real line timing. Expected
//   outputs come from the pixel index implied by the number of clock edges
//   since reset release.
// ----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

  // Small geometry: H 16+2+4+3 = 25, V 10+2+2+3 = 17, frame = 850 clk
  localparam int SD = 2, SHV = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVV = 10, SVF = 2, SVS = 2, SVB = 3;
  localparam int SFC = SD * (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] sw    = '0;

  logic       s_vga_clk, s_hs, s_vs, s_blank_n, s_sync_n, s_fs;
  logic [9:0] s_hcount, s_vcount;
  logic [8:0] s_color;
  logic       b_vga_clk, b_hs, b_vs, b_blank_n, b_sync_n, b_fs;
  logic [9:0] b_hcount, b_vcount;
  logic [8:0] b_color;

  vga_timing_ctrl #(
    .CLK_DIV(SD), .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .vga_clk(s_vga_clk), .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank_n(s_blank_n),
    .vga_sync_n(s_sync_n), .hcount(s_hcount), .vcount(s_vcount),
    .frame_start(s_fs), .color_sw(s_color)
  );

  vga_timing_ctrl u_big (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .vga_clk(b_vga_clk), .vga_hs(b_hs), .vga_vs(b_vs), .vga_blank_n(b_blank_n),
    .vga_sync_n(b_sync_n), .hcount(b_hcount), .vcount(b_vcount),
    .frame_start(b_fs), .color_sw(b_color)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       vclk;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       fs;
    logic [9:0] h;
    logic [9:0] v;
  } exp_t;

  // Outputs after e clock edges since reset release, from raster arithmetic.
  function automatic exp_t model(input int e, input int div,
                                 input int hv, input int hfp, input int hsw, input int hbp,
                                 input int vv, input int vfp, input int vsw, input int vbp);
    int ht, vt, n, h, v;
    exp_t r;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    n  = e / div;
    h  = n % ht;
    v  = (n / ht) % vt;
    r.h       = 10'(h);
    r.v       = 10'(v);
    r.vclk    = ((e % div) >= (div / 2));
    r.hs      = !((h >= hv + hfp) && (h < hv + hfp + hsw));
    r.vs      = !((v >= vv + vfp) && (v < vv + vfp + vsw));
    r.blank_n = (h < hv) && (v < vv);
    r.fs      = (e > 0) && ((e % (div * ht * vt)) == 0);
    return r;
  endfunction

  // Edge count since release plus sampled switch history; colour is taken
  // from the switch value sampled two edges before a frame-wrap edge.
  int         m_e;
  logic [8:0] m_hist [4];
  logic [8:0] m_color;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e     <= 0;
      m_color <= '0;
      for (int i = 0; i < 4; i++) m_hist[i] <= '0;
    end else begin
      m_e <= m_e + 1;
      m_hist[(m_e + 1) % 4] <= sw;
      if (((m_e + 1) % SFC) == 0) m_color <= m_hist[(m_e + 3) % 4];
    end
  end

  always @(negedge clk) begin
    exp_t es, eb;
    es = model(m_e, SD, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
    eb = model(m_e, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    chk("s_hcount",  32'(s_hcount),  32'(es.h));
    chk("s_vcount",  32'(s_vcount),  32'(es.v));
    chk("s_vga_clk", 32'(s_vga_clk), 32'(es.vclk));
    chk("s_hs",      32'(s_hs),      32'(es.hs));
    chk("s_vs",      32'(s_vs),      32'(es.vs));
    chk("s_blank_n", 32'(s_blank_n), 32'(es.blank_n));
    chk("s_fs",      32'(s_fs),      32'(es.fs));
    chk("s_color",   32'(s_color),   32'(m_color));
    chk("s_sync_n",  32'(s_sync_n),  32'd0);
    chk("b_hcount",  32'(b_hcount),  32'(eb.h));
    chk("b_vcount",  32'(b_vcount),  32'(eb.v));
    chk("b_vga_clk", 32'(b_vga_clk), 32'(eb.vclk));
    chk("b_hs",      32'(b_hs),      32'(eb.hs));
    chk("b_vs",      32'(b_vs),      32'(eb.vs));
    chk("b_blank_n", 32'(b_blank_n), 32'(eb.blank_n));
    chk("b_fs",      32'(b_fs),      32'(eb.fs));
    chk("b_sync_n",  32'(b_sync_n),  32'd0);
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_hcount"}, 32'(s_hcount),  32'd0);
    chk({tag, "_s_vcount"}, 32'(s_vcount),  32'd0);
    chk({tag, "_s_hs"},     32'(s_hs),      32'd1);
    chk({tag, "_s_vs"},     32'(s_vs),      32'd1);
    chk({tag, "_s_blank"},  32'(s_blank_n), 32'd1);
    chk({tag, "_s_fs"},     32'(s_fs),      32'd0);
    chk({tag, "_s_color"},  32'(s_color),   32'd0);
    chk({tag, "_s_vclk"},   32'(s_vga_clk), 32'd0);
    chk({tag, "_b_hcount"}, 32'(b_hcount),  32'd0);
    chk({tag, "_b_vcount"}, 32'(b_vcount),  32'd0);
  endtask

  initial begin
    int b_blank_fall1, b_blank_fall2, b_hs_fall, b_hs_rise, b_line;
    int fs_cnt, vs_low;
    bit blank_rehigh, found;
    int hs_k;

    b_blank_fall1 = -1; b_blank_fall2 = -1; b_hs_fall = -1; b_hs_rise = -1;
    b_line = -1; fs_cnt = 0; vs_low = 0; blank_rehigh = 0;

    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    #2 rst_n = 1'b1;

    for (int k = 1; k <= 3300; k++) begin
      @(negedge clk);
      // Big instance: real 640x480 line timing in clk cycles
      if (b_blank_fall1 < 0 && !b_blank_n) b_blank_fall1 = k;
      if (b_blank_fall1 >= 0 && b_blank_n) blank_rehigh = 1;
      if (blank_rehigh && !b_blank_n && b_blank_fall2 < 0) b_blank_fall2 = k;
      if (b_hs_fall < 0 && !b_hs) b_hs_fall = k;
      if (b_hs_fall >= 0 && b_hs && b_hs_rise < 0) b_hs_rise = k;
      if (b_line < 0 && k > 1 && b_hcount == 10'd0) b_line = k;
      // Small instance: frame pulses and vsync width
      if (s_fs) fs_cnt++;
      if (k <= SFC && !s_vs) vs_low++;
      // Colour latch scenario
      case (k)
        200:  sw = 9'h1C0;
        849:  chk("color_before_wrap", 32'(s_color), 32'h000);
        850:  begin
                chk("color_at_wrap", 32'(s_color), 32'h1C0);
                chk("fs_at_wrap",    32'(s_fs),    32'd1);
              end
        851:  chk("fs_width", 32'(s_fs), 32'd0);
        1698: sw = 9'h03F;
        1700: begin
                chk("late_toggle_ignored", 32'(s_color), 32'h1C0);
                chk("fs_at_wrap2",         32'(s_fs),    32'd1);
              end
        2550: chk("late_toggle_next_frame", 32'(s_color), 32'h03F);
        default: ;
      endcase
    end

    chk("blank_fall_clk", 32'(b_blank_fall1), 32'd1280);
    chk("hs_fall_clk",    32'(b_hs_fall),     32'd1312);
    chk("hs_width",       32'(b_hs_rise - b_hs_fall), 32'd192);
    chk("line_period",    32'(b_line),        32'd1600);
    chk("blank_period",   32'(b_blank_fall2 - b_blank_fall1), 32'd1600);
    chk("fs_count",       32'(fs_cnt),        32'd3);
    chk("vs_low_clks",    32'(vs_low),        32'd100);

    // Reset mid-frame while both syncs are low (hcount=19, vcount=12)
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (s_hcount == 10'd19 && s_vcount == 10'd12) found = 1;
    end
    chk("reset_point_found", 32'(found), 32'd1);
    chk("pre_reset_hs", 32'(s_hs), 32'd0);
    chk("pre_reset_vs", 32'(s_vs), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    hs_k = -1;
    for (int k = 1; k <= 100 && hs_k < 0; k++) begin
      @(negedge clk);
      if (!s_hs) begin
        hs_k = k;
        chk("post_reset_hs_h", 32'(s_hcount), 32'd18);
        chk("post_reset_hs_v", 32'(s_vcount), 32'd0);
      end
    end
    chk("post_reset_hs_clk", 32'(hs_k), 32'd36);

    repeat (900) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
